// File: rtl/e_mdu_iter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_iter_pkg
//  Purpose  : Shared operation codes, FSM state encodings and decode helpers
//             for the iterative E-stage multiply/divide unit.
//  Revision : 1.0  initial iterative MDU with accumulate modes
// ============================================================================
package e_mdu_iter_pkg;

    // Operation codes carried on MDType
    localparam logic [3:0] mdu_none  = 4'd0;
    localparam logic [3:0] mdu_mult  = 4'd1;
    localparam logic [3:0] mdu_multu = 4'd2;
    localparam logic [3:0] mdu_div   = 4'd3;
    localparam logic [3:0] mdu_divu  = 4'd4;
    localparam logic [3:0] mdu_mfhi  = 4'd5;
    localparam logic [3:0] mdu_mflo  = 4'd6;
    localparam logic [3:0] mdu_mthi  = 4'd7;
    localparam logic [3:0] mdu_mtlo  = 4'd8;
    localparam logic [3:0] mdu_madd  = 4'd9;
    localparam logic [3:0] mdu_maddu = 4'd10;
    localparam logic [3:0] mdu_msub  = 4'd11;
    localparam logic [3:0] mdu_msubu = 4'd12;

    // FSM state encodings
    localparam logic [1:0] MDU_IDLE = 2'd0;
    localparam logic [1:0] MDU_RUN  = 2'd1;
    localparam logic [1:0] MDU_PAD  = 2'd2;
    localparam logic [1:0] MDU_FIX  = 2'd3;

    // Operations that occupy the iterative datapath
    function automatic logic is_md_op(input logic [3:0] op);
        return op inside {mdu_mult, mdu_multu, mdu_div, mdu_divu,
                          mdu_madd, mdu_maddu, mdu_msub, mdu_msubu};
    endfunction

    // Operations whose operands are two's-complement
    function automatic logic is_signed_op(input logic [3:0] op);
        return op inside {mdu_mult, mdu_div, mdu_madd, mdu_msub};
    endfunction

    function automatic logic is_div_op(input logic [3:0] op);
        return op inside {mdu_div, mdu_divu};
    endfunction

endpackage
`default_nettype wire

// File: rtl/e_mdu_iter_if.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_iter_if
//  Purpose  : Operand / result bundle between the E stage and the MDU.
//  Ports    : A, B, MDType, Flush   (E stage -> MDU)
//             HIOut, LOOut, Start, Busy, Done   (MDU -> E stage)
//  Revision : 1.0  initial
// ============================================================================
interface e_mdu_iter_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       MDType;
    logic             Flush;
    logic [WIDTH-1:0] HIOut;
    logic [WIDTH-1:0] LOOut;
    logic             Start;
    logic             Busy;
    logic             Done;

    modport master (
        output A, B, MDType, Flush,
        input  HIOut, LOOut, Start, Busy, Done
    );

    modport slave (
        input  A, B, MDType, Flush,
        output HIOut, LOOut, Start, Busy, Done
    );
endinterface
`default_nettype wire

// File: rtl/e_mdu_divstep.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_divstep
//  Purpose  : One combinational restoring-division step. The quotient
//             register doubles as the dividend shift register: its MSB is
//             shifted into the partial remainder and the new quotient bit
//             enters at the LSB.
//  Ports    : i_rem / i_quo / i_divisor in, o_rem / o_quo out
//  Revision : 1.0  initial
// ============================================================================
module e_mdu_divstep #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_quo,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_quo
);
    logic [WIDTH:0] w_shift;
    logic [WIDTH:0] w_diff;
    logic           w_fits;

    assign w_shift = {i_rem, i_quo[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, i_divisor};
    // Borrow out of the top bit means the divisor did not fit.
    assign w_fits  = ~w_diff[WIDTH];

    // Partial remainder is always below the divisor, so when the
    // subtraction is rejected the shifted value still fits in WIDTH bits.
    assign o_rem = w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
    assign o_quo = {i_quo[WIDTH-2:0], w_fits};
endmodule
`default_nettype wire

// File: rtl/e_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu_iter
//  Purpose  : Iterative radix-2 multiply / restoring divide unit with
//             multiply-accumulate, owning the architectural HI/LO registers.
//  Ports    : Clk, Reset_n (async, active low)
//             bus.A/B operands, bus.MDType op, bus.Flush cancel
//             bus.HIOut/LOOut, bus.Start (comb), bus.Busy, bus.Done (pulse)
//  Revision : 1.0  initial
// ============================================================================
module e_mdu_iter
    import e_mdu_iter_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int EXTRA_LAT = 0
) (
    input  logic          Clk,
    input  logic          Reset_n,
    e_mdu_iter_if.slave   bus
);
    localparam int             CW          = $clog2(WIDTH + EXTRA_LAT + 1);
    localparam logic [CW-1:0]  C_CNT_RUN   = CW'(WIDTH);
    localparam logic [CW-1:0]  C_CNT_PAD   = CW'(EXTRA_LAT);
    localparam logic           C_HAS_PAD   = (EXTRA_LAT > 0);

    logic [1:0]       r_state;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_op;
    logic             r_neg_q;   // product / quotient must be negated
    logic             r_neg_a;   // remainder takes dividend sign
    logic [WIDTH-1:0] r_b;       // |multiplicand| or |divisor|
    logic [WIDTH-1:0] r_ph;      // product high / partial remainder
    logic [WIDTH-1:0] r_pl;      // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             r_done;

    logic             w_start;
    logic             w_sgn;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [WIDTH-1:0] w_a_mag;
    logic [WIDTH-1:0] w_b_mag;
    logic [WIDTH:0]   w_mul_sum;
    logic [WIDTH-1:0] w_div_rem;
    logic [WIDTH-1:0] w_div_quo;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_fix;

    assign w_start = Reset_n && (r_state == MDU_IDLE) && is_md_op(bus.MDType) && !bus.Flush;
    assign w_sgn   = is_signed_op(bus.MDType);
    assign w_a_neg = w_sgn && bus.A[WIDTH-1];
    assign w_b_neg = w_sgn && bus.B[WIDTH-1];
    assign w_a_mag = w_a_neg ? -bus.A : bus.A;
    assign w_b_mag = w_b_neg ? -bus.B : bus.B;

    // Shift-add: the carry out of the add becomes the new top product bit.
    assign w_mul_sum = {1'b0, r_ph} + (r_pl[0] ? {1'b0, r_b} : '0);

    e_mdu_divstep #(.WIDTH(WIDTH)) u_divstep (
        .i_rem     (r_ph),
        .i_quo     (r_pl),
        .i_divisor (r_b),
        .o_rem     (w_div_rem),
        .o_quo     (w_div_quo)
    );

    assign w_prod = r_neg_q ? -{r_ph, r_pl} : {r_ph, r_pl};

    // Result formed in FIX. Divide-by-zero leaves the dividend magnitude in
    // the remainder, so the ordinary remainder sign fix restores A exactly.
    always_comb begin
        w_fix = w_prod;
        case (r_op)
            mdu_madd, mdu_maddu: w_fix = {r_hi, r_lo} + w_prod;
            mdu_msub, mdu_msubu: w_fix = {r_hi, r_lo} - w_prod;
            mdu_div, mdu_divu: begin
                w_fix[2*WIDTH-1:WIDTH] = r_neg_a ? -r_ph : r_ph;
                if (r_b == '0)
                    w_fix[WIDTH-1:0] = '1;
                else
                    w_fix[WIDTH-1:0] = r_neg_q ? -r_pl : r_pl;
            end
            default: w_fix = w_prod;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= MDU_IDLE;
            r_cnt   <= '0;
            r_op    <= mdu_none;
            r_neg_q <= 1'b0;
            r_neg_a <= 1'b0;
            r_b     <= '0;
            r_ph    <= '0;
            r_pl    <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                MDU_IDLE: begin
                    if (w_start) begin
                        r_op    <= bus.MDType;
                        r_neg_q <= w_a_neg ^ w_b_neg;
                        r_neg_a <= w_a_neg;
                        r_b     <= w_b_mag;
                        r_ph    <= '0;
                        r_pl    <= w_a_mag;
                        r_cnt   <= C_CNT_RUN;
                        r_state <= MDU_RUN;
                    end else if (!bus.Flush) begin
                        if (bus.MDType == mdu_mthi) r_hi <= bus.A;
                        if (bus.MDType == mdu_mtlo) r_lo <= bus.A;
                    end
                end
                MDU_RUN: begin
                    if (bus.Flush) begin
                        r_state <= MDU_IDLE;
                    end else begin
                        if (is_div_op(r_op)) begin
                            r_ph <= w_div_rem;
                            r_pl <= w_div_quo;
                        end else begin
                            r_ph <= w_mul_sum[WIDTH:1];
                            r_pl <= {w_mul_sum[0], r_pl[WIDTH-1:1]};
                        end
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) begin
                            if (C_HAS_PAD) begin
                                r_cnt   <= C_CNT_PAD;
                                r_state <= MDU_PAD;
                            end else begin
                                r_state <= MDU_FIX;
                            end
                        end
                    end
                end
                MDU_PAD: begin
                    if (bus.Flush) begin
                        r_state <= MDU_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                        if (r_cnt == CW'(1)) r_state <= MDU_FIX;
                    end
                end
                MDU_FIX: begin
                    r_state <= MDU_IDLE;
                    if (!bus.Flush) begin
                        r_hi   <= w_fix[2*WIDTH-1:WIDTH];
                        r_lo   <= w_fix[WIDTH-1:0];
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= MDU_IDLE;
            endcase
        end
    end

    assign bus.Start = w_start;
    assign bus.Busy  = (r_state != MDU_IDLE);
    assign bus.Done  = r_done;
    assign bus.HIOut = r_hi;
    assign bus.LOOut = r_lo;
endmodule
`default_nettype wire

// File: tb/tb_e_mdu_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_e_mdu_iter
//  Purpose  : Self-checking bench for e_mdu_iter (WIDTH=32) with a second
//             instance at EXTRA_LAT=3. Expected HI/LO come from a 64-bit
//             arithmetic model of the instruction semantics.
//  Revision : 1.0  initial
// ============================================================================
module tb_e_mdu_iter;
    import e_mdu_iter_pkg::*;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [31:0] t_a = '0;
    logic [31:0] t_b = '0;
    logic [3:0]  t_op = mdu_none;
    logic        t_flush = 1'b0;
    bit          use3 = 1'b0;

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_hi [2];
    logic [31:0] m_lo [2];

    always #5 Clk = ~Clk;

    e_mdu_iter_if #(.WIDTH(32)) bus  ();
    e_mdu_iter_if #(.WIDTH(32)) bus3 ();

    assign bus.A       = t_a;
    assign bus.B       = t_b;
    assign bus.MDType  = use3 ? mdu_none : t_op;
    assign bus.Flush   = t_flush;
    assign bus3.A      = t_a;
    assign bus3.B      = t_b;
    assign bus3.MDType = use3 ? t_op : mdu_none;
    assign bus3.Flush  = t_flush;

    e_mdu_iter #(.WIDTH(32), .EXTRA_LAT(0)) dut  (.Clk(Clk), .Reset_n(Reset_n), .bus(bus.slave));
    e_mdu_iter #(.WIDTH(32), .EXTRA_LAT(3)) dut3 (.Clk(Clk), .Reset_n(Reset_n), .bus(bus3.slave));

    logic [31:0] o_hi, o_lo;
    logic        o_start, o_busy, o_done;
    assign o_hi    = use3 ? bus3.HIOut : bus.HIOut;
    assign o_lo    = use3 ? bus3.LOOut : bus.LOOut;
    assign o_start = use3 ? bus3.Start : bus.Start;
    assign o_busy  = use3 ? bus3.Busy  : bus.Busy;
    assign o_done  = use3 ? bus3.Done  : bus.Done;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Instruction-level reference semantics
    task automatic model_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int          s = use3 ? 1 : 0;
        longint      sa = $signed(a);
        longint      sb = $signed(b);
        logic [63:0] ua = {32'd0, a};
        logic [63:0] ub = {32'd0, b};
        logic [63:0] hilo = {m_hi[s], m_lo[s]};
        logic [63:0] p;
        longint      q, r;
        case (op)
            mdu_mult:  hilo = sa * sb;
            mdu_multu: hilo = ua * ub;
            mdu_madd:  begin p = sa * sb; hilo = hilo + p; end
            mdu_maddu: hilo = hilo + ua * ub;
            mdu_msub:  begin p = sa * sb; hilo = hilo - p; end
            mdu_msubu: hilo = hilo - ua * ub;
            mdu_div, mdu_divu: begin
                if (b == 32'd0) begin
                    hilo = {a, 32'hFFFF_FFFF};
                end else begin
                    if (op == mdu_div) begin q = sa / sb; r = sa % sb; end
                    else begin q = ua / ub; r = ua % ub; end
                    p = q;
                    hilo[31:0] = p[31:0];
                    p = r;
                    hilo[63:32] = p[31:0];
                end
            end
            default: ;
        endcase
        m_hi[s] = hilo[63:32];
        m_lo[s] = hilo[31:0];
    endtask

    task automatic do_md(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n = 0;
        int exp_busy = use3 ? 36 : 33;
        @(negedge Clk);
        t_a = a; t_b = b; t_op = op; t_flush = 1'b0;
        #1 chk("start", {63'd0, o_start}, 64'd1);
        @(posedge Clk);
        #1 t_op = mdu_none;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (o_busy) n++;
            else break;
        end
        model_md(op, a, b);
        chk("busy_len", 64'(n), 64'(exp_busy));
        chk("done",     {63'd0, o_done}, 64'd1);
        chk("hi",       {32'd0, o_hi}, {32'd0, m_hi[use3 ? 1 : 0]});
        chk("lo",       {32'd0, o_lo}, {32'd0, m_lo[use3 ? 1 : 0]});
        @(negedge Clk);
        chk("done_drop", {63'd0, o_done}, 64'd0);
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
        @(negedge Clk);
        t_a = a; t_op = op; t_flush = 1'b0;
        #1 chk("mt_nostart", {63'd0, o_start}, 64'd0);
        @(posedge Clk);
        #1 t_op = mdu_none;
        if (op == mdu_mthi) m_hi[use3 ? 1 : 0] = a;
        else                m_lo[use3 ? 1 : 0] = a;
        chk("mt_hi", {32'd0, o_hi}, {32'd0, m_hi[use3 ? 1 : 0]});
        chk("mt_lo", {32'd0, o_lo}, {32'd0, m_lo[use3 ? 1 : 0]});
    endtask

    initial begin
        #20000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops [8];
        logic [31:0] ra, rb;
        logic [3:0]  rop;
        ops[0] = mdu_mult; ops[1] = mdu_multu; ops[2] = mdu_div;  ops[3] = mdu_divu;
        ops[4] = mdu_madd; ops[5] = mdu_maddu; ops[6] = mdu_msub; ops[7] = mdu_msubu;
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;

        // Reset state, with an md op presented so Start gating is exercised
        t_op = mdu_mult;
        #12;
        chk("rst_hi",    {32'd0, o_hi}, 64'd0);
        chk("rst_lo",    {32'd0, o_lo}, 64'd0);
        chk("rst_busy",  {63'd0, o_busy}, 64'd0);
        chk("rst_done",  {63'd0, o_done}, 64'd0);
        chk("rst_start", {63'd0, o_start}, 64'd0);
        t_op = mdu_none;
        @(negedge Clk);
        Reset_n = 1'b1;

        // Directed plan
        do_md(mdu_mult,  32'hFFFF_FFFF, 32'd2);
        do_md(mdu_multu, 32'hFFFF_FFFF, 32'd2);
        do_md(mdu_div,   32'hFFFF_FFF9, 32'd2);
        do_md(mdu_div,   32'h8000_0000, 32'hFFFF_FFFF);
        do_md(mdu_divu,  32'h0000_1234, 32'd0);
        do_md(mdu_div,   32'hFFFF_FF00, 32'd0);
        do_mt(mdu_mthi,  32'd0);
        do_mt(mdu_mtlo,  32'd5);
        do_md(mdu_madd,  32'd3, 32'd4);
        do_md(mdu_msubu, 32'd1, 32'd20);

        // Flush 10 cycles into a multu: op cancelled, HI/LO untouched
        @(negedge Clk);
        t_a = 32'hDEAD_BEEF; t_b = 32'h1234_5678; t_op = mdu_multu;
        @(posedge Clk);
        #1 t_op = mdu_none;
        repeat (10) @(negedge Clk);
        t_flush = 1'b1;
        @(negedge Clk);
        t_flush = 1'b0;
        chk("flush_busy", {63'd0, o_busy}, 64'd0);
        chk("flush_hi",   {32'd0, o_hi}, {32'd0, m_hi[0]});
        chk("flush_lo",   {32'd0, o_lo}, {32'd0, m_lo[0]});
        for (int i = 0; i < 3; i++) begin
            chk("flush_nodone", {63'd0, o_done}, 64'd0);
            @(negedge Clk);
        end

        // Flush in IDLE suppresses both an md op and mthi
        t_a = 32'h5555_AAAA; t_op = mdu_mthi; t_flush = 1'b1;
        #1 chk("flush_idle_start", {63'd0, o_start}, 64'd0);
        @(negedge Clk);
        chk("flush_idle_hi", {32'd0, o_hi}, {32'd0, m_hi[0]});
        t_op = mdu_mult;
        #1 chk("flush_idle_mdstart", {63'd0, o_start}, 64'd0);
        @(negedge Clk);
        chk("flush_idle_busy", {63'd0, o_busy}, 64'd0);
        t_op = mdu_none; t_flush = 1'b0;

        // Randomized ops against the model, mt* interleaved
        for (int k = 0; k < 14; k++) begin
            rop = ops[$urandom_range(0, 7)];
            ra  = $urandom;
            rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 300)));
            if (k % 5 == 2) do_mt(($urandom_range(0, 1) == 1) ? mdu_mthi : mdu_mtlo, $urandom);
            do_md(rop, ra, rb);
        end

        // EXTRA_LAT=3 instance: longer Busy window, same arithmetic
        use3 = 1'b1;
        do_md(mdu_multu, 32'hFFFF_FFFF, 32'd2);
        do_md(mdu_div,   32'hFFFF_FFF9, 32'd2);
        use3 = 1'b0;

        // Asynchronous reset mid-divide
        @(negedge Clk);
        t_a = 32'd1000; t_b = 32'd7; t_op = mdu_div;
        @(posedge Clk);
        #1 t_op = mdu_none;
        repeat (5) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, o_busy}, 64'd0);
        chk("arst_hi",   {32'd0, o_hi}, 64'd0);
        chk("arst_lo",   {32'd0, o_lo}, 64'd0);
        chk("arst_done", {63'd0, o_done}, 64'd0);
        m_hi[0] = '0; m_lo[0] = '0; m_hi[1] = '0; m_lo[1] = '0;
        @(negedge Clk);
        Reset_n = 1'b1;
        do_md(mdu_maddu, 32'd6, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
